// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense controller.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2,
    ST_FAULT  = 2'd3
  } vend_state_e;

  // Coin codes exchanged with the coin-acceptance FSM
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_FIVE = 2'b01;
  localparam logic [1:0] COIN_TEN  = 2'b10;

  localparam int DEF_QDEPTH        = 4;
  localparam int DEF_MOTOR_TIMEOUT = 1000;
  localparam int DEF_SOL_PULSE     = 50;
  localparam int DEF_INV_W         = 8;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vend_req_fifo.sv
// 1-bit request FIFO; a push into a full FIFO is accepted only when a pop happens the same cycle.
module vend_req_fifo
  import vend_pkg::*;
#(
  parameter int DEPTH = DEF_QDEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty,
  output logic empty_next
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] mem_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nx_s;
  logic             do_push_s;
  logic             do_pop_s;

  // accept/occupancy decisions
  always_comb begin
    do_pop_s   = pop && (count_r != {(AW+1){1'b0}});
    do_push_s  = push && ((count_r != DEPTH_C) || do_pop_s);
    count_nx_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_nx_s = count_r + (AW+1)'(1);
      2'b01:   count_nx_s = count_r - (AW+1)'(1);
      default: count_nx_s = count_r;
    endcase
  end

  // storage and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r    <= {DEPTH{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nx_s;
    end
  end

  assign dout       = mem_r[rd_ptr_r];
  assign full       = (count_r == DEPTH_C);
  assign empty      = (count_r == {(AW+1){1'b0}});
  assign empty_next = (count_nx_s == {(AW+1){1'b0}});

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense/change consumer: queues vend requests, runs the motor and change solenoid, tracks inventory.
// Optional VEND_STATS_EN builds a saturating 16-bit completed-vend counter on vend_count.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int QDEPTH        = DEF_QDEPTH,
  parameter int MOTOR_TIMEOUT = DEF_MOTOR_TIMEOUT,
  parameter int SOL_PULSE     = DEF_SOL_PULSE,
  parameter int INV_W         = DEF_INV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dispense,
  input  logic             chg5,
  input  logic             motor_done,
  input  logic             refill,
  input  logic [INV_W-1:0] refill_prod,
  input  logic [INV_W-1:0] refill_coin,
  output logic             motor_on,
  output logic             coin_ret,
  output logic             sold_out,
  output logic             exact_change,
  output logic             busy,
  output logic             overflow,
  output logic             change_owed,
  output logic             fault,
  output logic [15:0]      vend_count
);

  localparam int TMAX = (MOTOR_TIMEOUT > SOL_PULSE) ? MOTOR_TIMEOUT : SOL_PULSE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(MOTOR_TIMEOUT - 1);
  localparam logic [TW-1:0] SOL_LAST = TW'(SOL_PULSE - 1);

  vend_state_e      state_r, state_nx_s;
  logic [TW-1:0]    timer_r, timer_nx_s;
  logic             chg_r, chg_nx_s;
  logic [INV_W-1:0] prod_r, prod_nx_s;
  logic [INV_W-1:0] coin_r, coin_nx_s;
  logic             pop_s;
  logic             owed_set_s;
  logic             drop_s;
  logic             q_dout_s, q_full_s, q_empty_s, q_empty_nx_s;

  vend_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (dispense),
    .pop        (pop_s),
    .din        (chg5),
    .dout       (q_dout_s),
    .full       (q_full_s),
    .empty      (q_empty_s),
    .empty_next (q_empty_nx_s)
  );

  assign drop_s = dispense && q_full_s && !pop_s;

  // next-state, inventory and timer decisions
  always_comb begin
    state_nx_s = state_r;
    timer_nx_s = timer_r;
    chg_nx_s   = chg_r;
    prod_nx_s  = prod_r;
    coin_nx_s  = coin_r;
    pop_s      = 1'b0;
    owed_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (refill) begin
          prod_nx_s = refill_prod;
          coin_nx_s = refill_coin;
        end else if (!q_empty_s) begin
          pop_s = 1'b1;
          // an entry popped while sold out is simply discarded
          if (prod_r != {INV_W{1'b0}}) begin
            state_nx_s = ST_VEND;
            timer_nx_s = {TW{1'b0}};
            chg_nx_s   = q_dout_s;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_VEND: begin
        if (motor_done) begin
          prod_nx_s  = prod_r - INV_W'(1);
          timer_nx_s = {TW{1'b0}};
          if (chg_r && (coin_r != {INV_W{1'b0}})) begin
            state_nx_s = ST_CHANGE;
          end else if (chg_r) begin
            owed_set_s = 1'b1;
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else if (timer_r == TO_LAST) begin
          state_nx_s = ST_FAULT;
        end else begin
          timer_nx_s = timer_r + TW'(1);
        end
      end
      ST_CHANGE: begin
        if (timer_r == SOL_LAST) begin
          coin_nx_s  = coin_r - INV_W'(1);
          state_nx_s = ST_IDLE;
        end else begin
          timer_nx_s = timer_r + TW'(1);
        end
      end
      ST_FAULT: begin
        state_nx_s = ST_FAULT;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // state, inventory and registered outputs (derived from next-state values)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      timer_r      <= {TW{1'b0}};
      chg_r        <= 1'b0;
      prod_r       <= {INV_W{1'b0}};
      coin_r       <= {INV_W{1'b0}};
      motor_on     <= 1'b0;
      coin_ret     <= 1'b0;
      sold_out     <= 1'b1;
      exact_change <= 1'b1;
      busy         <= 1'b0;
      overflow     <= 1'b0;
      change_owed  <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      timer_r      <= timer_nx_s;
      chg_r        <= chg_nx_s;
      prod_r       <= prod_nx_s;
      coin_r       <= coin_nx_s;
      motor_on     <= (state_nx_s == ST_VEND);
      coin_ret     <= (state_nx_s == ST_CHANGE);
      sold_out     <= (prod_nx_s == {INV_W{1'b0}});
      exact_change <= (coin_nx_s == {INV_W{1'b0}});
      busy         <= (state_nx_s != ST_IDLE) || !q_empty_nx_s;
      overflow     <= overflow | drop_s;
      change_owed  <= change_owed | owed_set_s;
      fault        <= (state_nx_s == ST_FAULT);
    end
  end

`ifdef VEND_STATS_EN
  logic [15:0] vend_count_r;

  // completed-vend counter, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      vend_count_r <= 16'h0000;
    end else if ((state_r == ST_VEND) && motor_done) begin
      vend_count_r <= sat_inc16(vend_count_r);
    end else begin
      vend_count_r <= vend_count_r;
    end
  end

  assign vend_count = vend_count_r;
`else
  assign vend_count = 16'h0000;
`endif

endmodule
